// File: rtl/roc_pkg.sv
// Shared types and constants for the rank-order-coding encoder.
package roc_pkg;

  typedef enum logic [2:0] {IDLE, PRE, LOAD, EMIT, FINISH} state_t;

  // Widest pixel supported; narrower builds take the low bits, which are still all ones.
  localparam int MAX_PIXEL_BITS = 30;
  localparam int MAX_INTENSITY  = (1 << MAX_PIXEL_BITS) - 1;

  // AER reset word {0,1,1...1}: bit AER_BITS-2 set, which no pixel index can reach.
  function automatic logic [31:0] rst_word(input int aer_bits);
    return (32'd1 << (aer_bits - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/roc_encoder_par_if.sv
// AER word handshake between the ROC encoder (master) and the AER input controller (slave).
interface roc_encoder_par_if #(
  parameter int AER_BITS = 10
);
  logic [AER_BITS-1:0] AER_ADDR;
  logic                AER_VALID;
  logic                AER_READY;

  modport master (output AER_ADDR, output AER_VALID, input AER_READY);
  modport slave  (input AER_ADDR, input AER_VALID, output AER_READY);
endinterface

// File: rtl/roc_lane_select.sv
// Lowest-set-lane picker for the per-window match mask; purely combinational.
module roc_lane_select #(
  parameter  int LANES = 4,
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic [LANES-1:0] mask,
  output logic [LW-1:0]    lane,
  output logic             any_set
);

  // Scan from the top so the lowest set bit is the last to write.
  always_comb begin
    lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) lane = LW'(i);
    end
  end

  assign any_set = |mask;

endmodule

// File: rtl/roc_encoder_par.sv
// ROC encoder: preamble words, then pixel indices brightest-first, LANES pixels per window.
// Build option ROC_SNAPSHOT_EN: capture IMAGE on START so the source may change while BUSY.
module roc_encoder_par
  import roc_pkg::*;
#(
  parameter  int IMAGE_SIZE     = 256,
  parameter  int PIXEL_BITS     = 8,
  parameter  int LANES          = 4,
  parameter  int AER_BITS       = 10,
  parameter  int PREAMBLE_WORDS = 2,
  parameter  int MAX_SPIKES     = IMAGE_SIZE,
  localparam int SC_BITS        = $clog2(MAX_SPIKES + 1),
  localparam int IW             = (IMAGE_SIZE > 1) ? $clog2(IMAGE_SIZE) : 1,
  localparam int LW             = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [PIXEL_BITS-1:0] IMAGE [IMAGE_SIZE],
  input  logic                  START,
  input  logic [PIXEL_BITS-1:0] MIN_INTENSITY,
  input  logic                  ABORT,
  roc_encoder_par_if.master     aer,
  output logic [SC_BITS-1:0]    SPIKE_COUNT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam logic [AER_BITS-1:0]   RST_W      = AER_BITS'(rst_word(AER_BITS));
  localparam logic [PIXEL_BITS-1:0] TOP_LEVEL  = PIXEL_BITS'(MAX_INTENSITY);
  localparam logic [IW-1:0]         LAST_BASE  = IW'(IMAGE_SIZE - LANES);
  localparam logic [IW-1:0]         BASE_STEP  = IW'(LANES);
  localparam logic [2:0]            PRE_LAST   = 3'(PREAMBLE_WORDS - 1);
  localparam logic [SC_BITS-1:0]    SPIKE_LAST = SC_BITS'(MAX_SPIKES - 1);

  state_t                state_reg;
  logic [IW-1:0]         base_reg;
  logic [PIXEL_BITS-1:0] intensity_reg;
  logic [PIXEL_BITS-1:0] floor_reg;
  logic [2:0]            pre_cnt_reg;
  logic [LANES-1:0]      mask_reg;
  logic [SC_BITS-1:0]    spike_reg;
  logic [LANES-1:0]      match;
  logic [LW-1:0]         lane;
  logic                  any_set;
  logic                  hs;

`ifdef ROC_SNAPSHOT_EN
  logic [PIXEL_BITS-1:0] snap_reg [IMAGE_SIZE];

  always_ff @(posedge CLK) begin
    if (state_reg == IDLE && START) snap_reg <= IMAGE;
  end
`endif

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [IW-1:0] idx;
    assign idx = base_reg + IW'(gi);
`ifdef ROC_SNAPSHOT_EN
    assign match[gi] = (snap_reg[idx] == intensity_reg);
`else
    assign match[gi] = (IMAGE[idx] == intensity_reg);
`endif
  end

  roc_lane_select #(.LANES(LANES)) u_sel (
    .mask    (mask_reg),
    .lane    (lane),
    .any_set (any_set)
  );

  // Outputs decode registered state only, so READY never reaches VALID/ADDR.
  always_comb begin
    aer.AER_VALID = 1'b0;
    aer.AER_ADDR  = '0;
    if (state_reg == PRE) begin
      aer.AER_VALID = 1'b1;
      aer.AER_ADDR  = RST_W;
    end else if (state_reg == EMIT && any_set) begin
      aer.AER_VALID = 1'b1;
      aer.AER_ADDR  = AER_BITS'(base_reg + IW'(lane));
    end
  end

  assign hs          = aer.AER_VALID & aer.AER_READY;
  assign SPIKE_COUNT = spike_reg;
  assign BUSY        = (state_reg != IDLE);
  assign DONE        = (state_reg == FINISH);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg     <= IDLE;
      base_reg      <= '0;
      intensity_reg <= '0;
      floor_reg     <= '0;
      pre_cnt_reg   <= '0;
      mask_reg      <= '0;
      spike_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (START) begin
            spike_reg     <= '0;
            intensity_reg <= TOP_LEVEL;
            base_reg      <= '0;
            floor_reg     <= MIN_INTENSITY;
            pre_cnt_reg   <= '0;
            state_reg     <= (PREAMBLE_WORDS == 0) ? LOAD : PRE;
          end
        end
        PRE: begin
          if (hs) begin
            pre_cnt_reg <= pre_cnt_reg + 3'd1;
            if (pre_cnt_reg == PRE_LAST) state_reg <= LOAD;
          end
        end
        LOAD: begin
          mask_reg  <= match;
          state_reg <= EMIT;
        end
        EMIT: begin
          if (any_set) begin
            if (hs) begin
              mask_reg  <= mask_reg & ~(LANES'(1) << lane);
              spike_reg <= spike_reg + SC_BITS'(1);
              if (spike_reg == SPIKE_LAST) state_reg <= FINISH;
            end
          end else if (base_reg == LAST_BASE) begin
            // Floor test comes before the decrement, so the level never wraps.
            base_reg <= '0;
            if (intensity_reg == floor_reg) begin
              state_reg <= FINISH;
            end else begin
              intensity_reg <= intensity_reg - PIXEL_BITS'(1);
              state_reg     <= LOAD;
            end
          end else begin
            base_reg  <= base_reg + BASE_STEP;
            state_reg <= LOAD;
          end
        end
        FINISH:  state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      if (ABORT && (state_reg == PRE || state_reg == LOAD || state_reg == EMIT))
        state_reg <= FINISH;
    end
  end

endmodule

// File: tb/tb_roc_encoder_par.sv
// Directed bench for roc_encoder_par: default, spike-budget, LANES=1 and LANES=8 builds.
`timescale 1ns/1ps
module tb_roc_encoder_par;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic check_seq(input string tag, input logic [9:0] got[$], input logic [9:0] exp[$]);
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_w%0d", tag, i), (i < got.size()) ? int'(got[i]) : -1, int'(exp[i]));
  endtask

  // DUT A: default parameters
  logic [7:0] img_a [256];
  logic       start_a, abort_a, busy_a, done_a;
  logic [7:0] min_a;
  logic [8:0] spike_a;
  roc_encoder_par_if #(.AER_BITS(10)) aer_a ();
  roc_encoder_par dut_a (
    .CLK(CLK), .RST(RST), .IMAGE(img_a), .START(start_a), .MIN_INTENSITY(min_a),
    .ABORT(abort_a), .aer(aer_a), .SPIKE_COUNT(spike_a), .BUSY(busy_a), .DONE(done_a));

  // DUT B: spike budget of 2
  logic [7:0] img_b [256];
  logic       start_b, busy_b, done_b;
  logic [1:0] spike_b;
  roc_encoder_par_if #(.AER_BITS(10)) aer_b ();
  roc_encoder_par #(.MAX_SPIKES(2)) dut_b (
    .CLK(CLK), .RST(RST), .IMAGE(img_b), .START(start_b), .MIN_INTENSITY(8'd0),
    .ABORT(1'b0), .aer(aer_b), .SPIKE_COUNT(spike_b), .BUSY(busy_b), .DONE(done_b));

  // DUT C (LANES=1) and DUT D (LANES=8) on a shared 16-pixel 4-bit image
  logic [3:0] img_s [16];
  logic       start_s, busy_c, done_c, busy_d, done_d;
  logic [4:0] spike_c, spike_d;
  roc_encoder_par_if #(.AER_BITS(10)) aer_c ();
  roc_encoder_par_if #(.AER_BITS(10)) aer_d ();
  roc_encoder_par #(.IMAGE_SIZE(16), .PIXEL_BITS(4), .LANES(1)) dut_c (
    .CLK(CLK), .RST(RST), .IMAGE(img_s), .START(start_s), .MIN_INTENSITY(4'd0),
    .ABORT(1'b0), .aer(aer_c), .SPIKE_COUNT(spike_c), .BUSY(busy_c), .DONE(done_c));
  roc_encoder_par #(.IMAGE_SIZE(16), .PIXEL_BITS(4), .LANES(8)) dut_d (
    .CLK(CLK), .RST(RST), .IMAGE(img_s), .START(start_s), .MIN_INTENSITY(4'd0),
    .ABORT(1'b0), .aer(aer_d), .SPIKE_COUNT(spike_d), .BUSY(busy_d), .DONE(done_d));

  // Accepted words and DONE pulses, sampled mid-cycle ahead of the edge that takes them.
  logic [9:0] q_a[$], q_b[$], q_c[$], q_d[$];
  int done_n_a = 0, done_n_b = 0, done_n_c = 0, done_n_d = 0;
  int hs_cyc_b = 0, done_cyc_b = 0;

  always @(negedge CLK) begin
    if (aer_a.AER_VALID && aer_a.AER_READY) q_a.push_back(aer_a.AER_ADDR);
    if (aer_b.AER_VALID && aer_b.AER_READY) begin
      q_b.push_back(aer_b.AER_ADDR);
      hs_cyc_b = cyc;
    end
    if (aer_c.AER_VALID && aer_c.AER_READY) q_c.push_back(aer_c.AER_ADDR);
    if (aer_d.AER_VALID && aer_d.AER_READY) q_d.push_back(aer_d.AER_ADDR);
    if (done_a) done_n_a++;
    if (done_b) begin
      done_n_b++;
      done_cyc_b = cyc;
    end
    if (done_c) done_n_c++;
    if (done_d) done_n_d++;
  end

  task automatic wait_done_a(input string tag, input int budget);
    int c = 0;
    while (!done_a && c < budget) begin
      @(posedge CLK); #1;
      c++;
    end
    if (!done_a) check({tag, "_timeout"}, 0, 1);
  endtask

  task automatic start_a_run(input logic [7:0] mn);
    q_a.delete();
    done_n_a = 0;
    min_a    = mn;
    start_a  = 1'b1;
    @(posedge CLK); #1;
    start_a  = 1'b0;
  endtask

  logic [9:0] exp[$];
  int         ord[16];
  int         tmp;
  logic       stalled, aborted;

  initial begin
    RST = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; min_a = 8'd0; start_b = 1'b0; start_s = 1'b0;
    aer_a.AER_READY = 1'b0; aer_b.AER_READY = 1'b1;
    aer_c.AER_READY = 1'b1; aer_d.AER_READY = 1'b1;
    foreach (img_a[i]) img_a[i] = 8'd0;
    foreach (img_b[i]) img_b[i] = 8'd50;
    foreach (img_s[i]) img_s[i] = 4'($urandom_range(0, 15));
    img_s[12] = img_s[5];
    repeat (3) @(posedge CLK);
    #1;
    check("rst_valid", int'(aer_a.AER_VALID), 0);
    check("rst_addr",  int'(aer_a.AER_ADDR), 0);
    check("rst_spike", int'(spike_a), 0);
    check("rst_busy",  int'(busy_a), 0);
    check("rst_done",  int'(done_a), 0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // t1: sparse image, floor 0; B, C and D run alongside
    img_a[7] = 8'd255; img_a[3] = 8'd128; img_a[200] = 8'd128;
    aer_a.AER_READY = 1'b1;
    start_b = 1'b1; start_s = 1'b1;
    start_a_run(8'd0);
    start_b = 1'b0; start_s = 1'b0;
    check("t1_busy",      int'(busy_a), 1);
    check("t1_pre_valid", int'(aer_a.AER_VALID), 1);
    check("t1_pre_addr",  int'(aer_a.AER_ADDR), 'h1FF);
    wait_done_a("t1", 40000);
    check("t1_spikes", int'(spike_a), 256);
    @(posedge CLK); #1;
    check("t1_idle", int'(busy_a), 0);
    exp = {10'h1FF, 10'h1FF, 10'd7, 10'd3, 10'd200};
    for (int i = 0; i < 256; i++)
      if (i != 3 && i != 7 && i != 200) exp.push_back(10'(i));
    check_seq("t1", q_a, exp);
    check("t1_done_n", done_n_a, 1);
    $display("t1: %0d words, spikes=%0d", q_a.size(), spike_a);

    // t3: spike budget on B
    check_seq("t3", q_b, {10'h1FF, 10'h1FF, 10'd0, 10'd1});
    check("t3_spikes", int'(spike_b), 2);
    check("t3_done_n", done_n_b, 1);
    check("t3_finish_gap", done_cyc_b - hs_cyc_b, 1);
    check("t3_idle", int'(busy_b), 0);
    $display("t3: %0d words, spikes=%0d", q_b.size(), spike_b);

    // t6: LANES=1 and LANES=8 against a stable insertion sort
    for (int i = 0; i < 16; i++) ord[i] = i;
    for (int i = 1; i < 16; i++)
      for (int j = i; j > 0 && img_s[ord[j-1]] < img_s[ord[j]]; j--) begin
        tmp = ord[j]; ord[j] = ord[j-1]; ord[j-1] = tmp;
      end
    exp = {10'h1FF, 10'h1FF};
    for (int i = 0; i < 16; i++) exp.push_back(10'(ord[i]));
    check_seq("t6_l1", q_c, exp);
    check_seq("t6_l8", q_d, exp);
    check("t6_l1_spikes", int'(spike_c), 16);
    check("t6_l8_spikes", int'(spike_d), 16);
    check("t6_l1_done_n", done_n_c, 1);
    check("t6_l8_done_n", done_n_d, 1);
    $display("t6: lanes1 %0d words, lanes8 %0d words", q_c.size(), q_d.size());

    // t2: same image, floor 100
    start_a_run(8'd100);
    wait_done_a("t2", 25000);
    check("t2_spikes", int'(spike_a), 3);
    @(posedge CLK); #1;
    check_seq("t2", q_a, {10'h1FF, 10'h1FF, 10'd7, 10'd3, 10'd200});
    check("t2_done_n", done_n_a, 1);
    $display("t2: %0d words, spikes=%0d", q_a.size(), spike_a);

    // t4: READY low for 5 cycles while index 3 is offered
    foreach (img_a[i]) img_a[i] = 8'd0;
    img_a[7] = 8'd255; img_a[3] = 8'd254; img_a[200] = 8'd254;
    stalled = 1'b0;
    start_a_run(8'd250);
    for (int c = 0; c < 3000 && !done_a; c++) begin
      if (!stalled && aer_a.AER_VALID && aer_a.AER_ADDR == 10'd3) begin
        stalled = 1'b1;
        aer_a.AER_READY = 1'b0;
        for (int k = 0; k < 5; k++) begin
          @(posedge CLK); #1;
          check($sformatf("t4_hold_addr%0d", k), int'(aer_a.AER_ADDR), 3);
          check($sformatf("t4_hold_valid%0d", k), int'(aer_a.AER_VALID), 1);
        end
        aer_a.AER_READY = 1'b1;
      end
      @(posedge CLK); #1;
    end
    check("t4_stalled", int'(stalled), 1);
    check("t4_done", int'(done_a), 1);
    check("t4_spikes", int'(spike_a), 3);
    @(posedge CLK); #1;
    check_seq("t4", q_a, {10'h1FF, 10'h1FF, 10'd7, 10'd3, 10'd200});
    $display("t4: %0d words, spikes=%0d", q_a.size(), spike_a);

    // t5: ABORT coincident with the handshake of index 3, then a fresh run
    aborted = 1'b0;
    start_a_run(8'd250);
    for (int c = 0; c < 3000 && !aborted; c++) begin
      if (aer_a.AER_VALID && aer_a.AER_READY && aer_a.AER_ADDR == 10'd3) begin
        abort_a = 1'b1;
        @(posedge CLK); #1;
        abort_a = 1'b0;
        aborted = 1'b1;
        check("t5_valid_low", int'(aer_a.AER_VALID), 0);
        check("t5_done", int'(done_a), 1);
        check("t5_spikes", int'(spike_a), 2);
      end else begin
        @(posedge CLK); #1;
      end
    end
    check("t5_aborted", int'(aborted), 1);
    @(posedge CLK); #1;
    check("t5_idle", int'(busy_a), 0);
    check_seq("t5", q_a, {10'h1FF, 10'h1FF, 10'd7, 10'd3});
    check("t5_done_n", done_n_a, 1);
    $display("t5: aborted after %0d words, spikes=%0d", q_a.size(), spike_a);

    start_a_run(8'd250);
    check("t5r_pre_valid", int'(aer_a.AER_VALID), 1);
    check("t5r_pre_addr", int'(aer_a.AER_ADDR), 'h1FF);
    wait_done_a("t5r", 3000);
    check("t5r_spikes", int'(spike_a), 3);
    @(posedge CLK); #1;
    check_seq("t5r", q_a, {10'h1FF, 10'h1FF, 10'd7, 10'd3, 10'd200});
    $display("t5r: %0d words, spikes=%0d", q_a.size(), spike_a);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/roc_encoder_par.md
# roc_encoder_par

Parametrised rank-order-coding (ROC) encoder. On START it emits a short AER preamble of reset words, then the index of every image pixel in descending-intensity order: brightest first, ties by ascending index. It evaluates LANES pixels per cycle and talks to the AER input controller over a valid/ready handshake. Scanning stops at a programmable intensity floor, a spike budget, or an ABORT from the inference core.

## Interface
- IMAGE_SIZE, 256: pixel count; must be a multiple of LANES.
- PIXEL_BITS, 8: pixel width; maximum intensity is 2^PIXEL_BITS-1.
- LANES, 4: pixels compared per cycle; power of two, 1..32.
- AER_BITS, 10: AER address width; requires $clog2(IMAGE_SIZE) <= AER_BITS-2.
- PREAMBLE_WORDS, 2: reset words sent before the first index; 0..7.
- MAX_SPIKES, IMAGE_SIZE: spike budget per image.
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-high.
- IMAGE  in  [PIXEL_BITS-1:0] x IMAGE_SIZE  input image (unpacked array).
- START  in  1  begin encoding; sampled only in IDLE.
- MIN_INTENSITY  in  PIXEL_BITS  lowest intensity emitted; sampled on START.
- ABORT  in  1  terminate the current image (e.g. first inference done).
- AER_ADDR  out  AER_BITS  word presented to the AER controller.
- AER_VALID  out  1  AER_ADDR is valid.
- AER_READY  in  1  AER controller accepts the word.
- SPIKE_COUNT  out  $clog2(MAX_SPIKES+1)  pixel indices accepted for this image.
- BUSY  out  1  encoder is not in IDLE.
- DONE  out  1  one-cycle pulse at the end of an image.

## Operation
- States: IDLE, PRE, LOAD, EMIT, FINISH.
- IDLE, START=1 -> PRE.
  - Clear SPIKE_COUNT; set intensity=2^PIXEL_BITS-1 and base=0.
  - Latch MIN_INTENSITY.
  - If PREAMBLE_WORDS=0, go directly to LOAD.
- PRE: AER_VALID=1 and AER_ADDR=RST_WORD={1'b0,1'b1,{AER_BITS-2{1'b1}}} (0x1FF at 10 bits).
  - Each handshake (VALID&READY) increments the preamble counter.
  - The handshake that completes PREAMBLE_WORDS -> LOAD.
- LOAD (1 cycle): mask[l] = (IMAGE[base+l] == intensity) for l = 0..LANES-1, registered. -> EMIT.
- EMIT:
  - If mask != 0: AER_VALID=1 and AER_ADDR = zero-extended (base + lowest set lane).
  - On handshake: clear that mask bit and increment SPIKE_COUNT.
  - If mask == 0, the window is finished:
    - if base == IMAGE_SIZE-LANES: base=0; then, if intensity == latched MIN_INTENSITY -> FINISH, else decrement intensity -> LOAD;
    - otherwise base += LANES -> LOAD.
- Spike budget: the handshake that brings SPIKE_COUNT to MAX_SPIKES -> FINISH.
- FINISH: DONE=1 for one cycle, then -> IDLE.
- ABORT in PRE, LOAD or EMIT -> FINISH on the next edge.
  - AER_VALID drops even without a handshake; the AER controller tolerates a withdrawn word.
  - If a handshake occurs in the same cycle as ABORT, it completes and is counted.
- START outside IDLE is ignored. ABORT in IDLE or FINISH is ignored.
- Intensity counter is PIXEL_BITS wide and never underflows: the floor check precedes the decrement.
- MIN_INTENSITY=0 emits every pixel, zeros included.
- Data words never equal RST_WORD, because bit AER_BITS-2 of a data word is always 0.

## Timing
- Reset values: AER_VALID=0, AER_ADDR=0, SPIKE_COUNT=0, BUSY=0, DONE=0; state IDLE.
- All outputs are registered or decoded from registered state only. No combinational path from AER_READY to AER_VALID or AER_ADDR.
- AER_ADDR is stable while AER_VALID=1 and READY=0, except on ABORT.
- START to first preamble AER_VALID: 1 cycle.
- Empty window: 2 cycles (LOAD + EMIT).
- Window with k matches: 1+k cycles plus 1 closing EMIT cycle, assuming READY stays high.
- Full scan with no matches: 2·IMAGE_SIZE/LANES cycles per intensity level.
- BUSY is high from the cycle after START up to and including the FINISH cycle.
- RST mid-image returns to IDLE immediately and drops AER_VALID asynchronously.

## Configuration
- ROC_SNAPSHOT_EN defined:
  - IMAGE is copied into an internal register array on the START cycle; the comparators read the copy.
  - IMAGE may change while BUSY=1.
- ROC_SNAPSHOT_EN undefined:
  - Comparators read IMAGE directly; no snapshot storage.
  - IMAGE must be held stable from START until DONE; otherwise behaviour is undefined.

## Structure
- Package roc_pkg holds:
  - the state_t enum (IDLE, PRE, LOAD, EMIT, FINISH);
  - function rst_word(AER_BITS);
  - localparam for maximum intensity.
- Sub-module roc_lane_select: LANES-bit mask in; lowest-set index ($clog2(LANES) bits) and any-set flag out; purely combinational.
- Top level holds the FSM, the base, intensity, preamble and spike counters, the mask register and the optional snapshot.

## Test plan
- Defaults, READY=1, image all 0 except pixel 7=255, pixel 3=128, pixel 200=128, MIN=0: AER sequence 0x1FF, 0x1FF, 7, 3, 200, then every remaining pixel ascending; DONE once; SPIKE_COUNT=256.
- Same image, MIN_INTENSITY=100: words 0x1FF, 0x1FF, 7, 3, 200; DONE; SPIKE_COUNT=3.
- MAX_SPIKES=2, image all 50: words 0x1FF, 0x1FF, 0, 1; FINISH straight after the second index handshake.
- READY held low 5 cycles on index 3: AER_ADDR=3 stable throughout; no skipped or duplicated index.
- ABORT asserted in the same cycle as the handshake of index 3: 3 is counted (SPIKE_COUNT=2 after 7 and 3); AER_VALID low the next cycle; DONE pulse; START then re-runs from the preamble.
- LANES=1 and LANES=8 on a random image: AER sequence identical to a software stable sort by (intensity descending, index ascending).
